// File: rtl/gpu_ram_port_responder_pkg.sv
// Shared types and helpers for fixed-latency GPU RAM responders.
// Byte-lane selection is the one place endianness is decided.
package gpu_mem_pkg;

  localparam int GPU_ADDR_W = 20;
  localparam int GPU_DATA_W = 16;

  typedef struct packed {
    logic ena16;
    logic a0;
    logic in_range;
  } rd_tag_t;

  // Returns {hi_lane, lo_lane}; the even byte lives in the high lane when big-endian.
  function automatic logic [1:0] lane_sel(input logic a0, input logic big_endian);
    return (a0 ^ big_endian) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/gpu_ram_port_responder_if.sv
// GPU RAM request bus between the data mux (master) and a memory responder (slave).
interface gpu_ram_port_responder_if;

  logic                                gpu_wr_ena;
  logic                                gpu_ena_16bit;
  logic [gpu_mem_pkg::GPU_ADDR_W-1:0]  gpu_address;
  logic [gpu_mem_pkg::GPU_DATA_W-1:0]  gpu_data_out;
  logic [gpu_mem_pkg::GPU_DATA_W-1:0]  gpu_data_in;

  modport master (
    output gpu_wr_ena, gpu_ena_16bit, gpu_address, gpu_data_out,
    input  gpu_data_in
  );

  modport slave (
    input  gpu_wr_ena, gpu_ena_16bit, gpu_address, gpu_data_out,
    output gpu_data_in
  );

endinterface

// File: rtl/gpu_ram_port_responder_rd_tag_pipe.sv
// Fixed-depth shift register carrying read tags alongside a block RAM's read latency.
module gpu_rd_tag_pipe
  import gpu_mem_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    reset_n,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag
);

  rd_tag_t r_pipe [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_tag = r_pipe[DEPTH-1];

endmodule

// File: rtl/gpu_ram_port_responder.sv
// Memory-side responder: maps byte-addressed 8/16-bit GPU requests onto a 16-bit
// byte-enabled block RAM and returns lane-steered read data at fixed latency.
module gpu_ram_port_responder
  import gpu_mem_pkg::*;
#(
  parameter int READ_CLOCK_CYCLES = 2,
  parameter int RAM_LATENCY       = 1,
  parameter int MEM_WORDS         = 32768,
  parameter int RAM_AW            = 15,
  parameter int BIG_ENDIAN        = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  gpu_ram_port_responder_if.slave bus,
  output logic [RAM_AW-1:0]     ram_addr,
  output logic                  ram_wren,
  output logic [1:0]            ram_byteena,
  output logic [15:0]           ram_wdata,
  input  logic [15:0]           ram_rdata,
  input  logic                  err_clr,
  output logic                  oor_err,
  output logic                  align_err,
  output logic [7:0]            err_count
);

  if (READ_CLOCK_CYCLES != RAM_LATENCY + 1) begin : g_bad_latency
    $error("READ_CLOCK_CYCLES must equal RAM_LATENCY+1");
  end

  localparam logic BE = (BIG_ENDIAN != 0);

  logic [GPU_ADDR_W-2:0] w_word;
  logic                  w_in_range;
  logic                  w_err_oor;
  logic                  w_err_mis;
  rd_tag_t               w_tag_in;
  rd_tag_t               w_tag;
  logic [1:0]            w_rd_lane;
  logic [7:0]            w_rd_byte;
  logic [15:0]           w_rd_data;

  logic [15:0]           r_rdata;
  logic                  r_oor_err;
  logic                  r_align_err;
  logic [7:0]            r_err_count;

  // Request path: purely combinational, presented to the RAM in cycle 0.
  assign w_word     = bus.gpu_address[GPU_ADDR_W-1:1];
  assign w_in_range = ({13'd0, w_word} < MEM_WORDS[31:0]);
  assign ram_addr   = bus.gpu_address[RAM_AW:1];
  assign ram_wren   = reset_n & bus.gpu_wr_ena & w_in_range;

  always_comb begin
    ram_byteena = 2'b11;
    ram_wdata   = bus.gpu_data_out;
    if (!bus.gpu_ena_16bit) begin
      ram_byteena = lane_sel(bus.gpu_address[0], BE);
      ram_wdata   = {2{bus.gpu_data_out[7:0]}};
    end
  end

  assign w_tag_in = '{ena16: bus.gpu_ena_16bit, a0: bus.gpu_address[0], in_range: w_in_range};

  gpu_rd_tag_pipe #(.DEPTH(RAM_LATENCY)) u_tag_pipe (
    .clk    (clk),
    .reset_n(reset_n),
    .i_tag  (w_tag_in),
    .o_tag  (w_tag)
  );

  // Read steering uses the tag that emerges together with ram_rdata.
  always_comb begin
    w_rd_lane = lane_sel(w_tag.a0, BE);
    w_rd_byte = w_rd_lane[1] ? ram_rdata[15:8] : ram_rdata[7:0];
    w_rd_data = 16'h0000;
    if (w_tag.in_range) w_rd_data = w_tag.ena16 ? ram_rdata : {8'h00, w_rd_byte};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rdata <= 16'h0000;
    else          r_rdata <= w_rd_data;
  end

  assign bus.gpu_data_in = r_rdata;

  // Errors only count on write strobes; one event per write even if both kinds.
  assign w_err_oor = bus.gpu_wr_ena & ~w_in_range;
  assign w_err_mis = bus.gpu_wr_ena & bus.gpu_ena_16bit & bus.gpu_address[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_oor_err   <= 1'b0;
      r_align_err <= 1'b0;
      r_err_count <= 8'h00;
    end else if (err_clr) begin
      r_oor_err   <= 1'b0;
      r_align_err <= 1'b0;
      r_err_count <= 8'h00;
    end else begin
      if (w_err_oor) r_oor_err   <= 1'b1;
      if (w_err_mis) r_align_err <= 1'b1;
      if ((w_err_oor | w_err_mis) && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'h01;
    end
  end

  assign oor_err   = r_oor_err;
  assign align_err = r_align_err;
  assign err_count = r_err_count;

endmodule

// File: doc/gpu_ram_port_responder.md
Name: gpu_ram_port_responder

Overview:
- Memory-side responder for the GPU RAM request bus that the multi-port data mux drives (gpu_wr_ena, gpu_ena_16bit, gpu_address, gpu_data_out → gpu_data_in).
- Converts byte-addressed 8/16-bit requests into word accesses on a 16-bit synchronous block RAM with byte enables.
- Returns read data with exactly READ_CLOCK_CYCLES latency, lane-steered. Flags out-of-range and misaligned writes.

Parameters:
READ_CLOCK_CYCLES, 2, total request→gpu_data_in latency; must equal the mux setting; must equal RAM_LATENCY+1
RAM_LATENCY, 1, block-RAM read latency in clocks (1..8)
MEM_WORDS, 32768, implemented 16-bit words; word addresses ≥ MEM_WORDS are out of range
RAM_AW, 15, ram_addr width, ≥ clog2(MEM_WORDS)
BIG_ENDIAN, 1, 1: even byte address = bits[15:8]; 0: even byte = bits[7:0]

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
gpu_wr_ena  in  1  one-clock write strobe from mux
gpu_ena_16bit  in  1  1 = 16-bit access, 0 = 8-bit
gpu_address  in  20  byte address; valid every cycle (reads are implicit, every cycle)
gpu_data_out  in  16  write data; 8-bit writes use [7:0]
gpu_data_in  out  16  read data to mux
ram_addr  out  RAM_AW  word address = gpu_address[RAM_AW:1]
ram_wren  out  1  RAM write enable
ram_byteena  out  2  RAM byte enables, bit1 = [15:8]
ram_wdata  out  16  RAM write data
ram_rdata  in  16  RAM read data, RAM_LATENCY after ram_addr
err_clr  in  1  synchronous clear of error flags and counter
oor_err  out  1  sticky: write to out-of-range address seen
align_err  out  1  sticky: 16-bit write with gpu_address[0]=1 seen
err_count  out  8  saturating count of out-of-range plus misaligned writes

Behaviour:
- Reset (reset_n=0, async): gpu_data_in=0, all pipeline stages cleared, oor_err=0, align_err=0, err_count=0. ram_wren is forced to 0 while reset_n=0.
- Request path is combinational, cycle 0:
  - ram_addr = gpu_address[RAM_AW:1].
  - in_range = (gpu_address[19:1] < MEM_WORDS).
  - ram_wren = gpu_wr_ena & in_range.
- Write lane steering:
  - 16-bit: byteena=2'b11, ram_wdata = gpu_data_out. address[0] is ignored.
  - 8-bit: ram_wdata = {gpu_data_out[7:0], gpu_data_out[7:0]}. byteena selects one lane: even address → high lane if BIG_ENDIAN, else low; odd address → the other lane.
- Read pipeline:
  - Shift register of depth RAM_LATENCY carries {ena_16bit, address[0], in_range} alongside the RAM.
  - Output register samples on the cycle ram_rdata is valid, so gpu_data_in is valid at cycle READ_CLOCK_CYCLES after the address.
  - 16-bit result: ram_rdata. Byte order follows BIG_ENDIAN, so gpu_data_in[15:8] = even byte when BIG_ENDIAN=1; when BIG_ENDIAN=0 bytes are swapped.
  - 8-bit result: {8'h00, selected byte}.
  - Out-of-range read: 16'h0000.
- Read-during-write to the same word in the same cycle returns old data. A write followed by a read of the same word in the next cycle returns new data (RAM configured old-data / registered).
- Error logic, counted on writes only; idle address drift never counts:
  - Out-of-range write → oor_err=1, err_count+1.
  - 16-bit write with address[0]=1 → align_err=1, err_count+1. The write is still performed on the aligned word.
  - A write that is both counts once and sets both flags.
  - err_count saturates at 8'hFF.
  - err_clr in the same cycle as an error event: the clear wins, so flags and count are 0 next cycle.
- Back-to-back requests every clock are supported, with no stall and no backpressure.
- Reset mid-read: pipeline flushed; no stale data appears after release.

Decomposition:
- Shared package gpu_mem_pkg:
  - GPU_ADDR_W=20, GPU_DATA_W=16.
  - typedef struct rd_tag_t {logic ena16; logic a0; logic in_range;}.
  - function lane_sel(a0, big_endian) returning the byte-enable pair.
- Natural sub-module gpu_rd_tag_pipe: parameterised-depth shift register of rd_tag_t with async active-low reset. Reused by other fixed-latency RAM responders.

Test Plan:
- 8-bit write 8'hA5 @ addr 0x00010, BIG_ENDIAN=1 → ram_byteena=2'b10, ram_wdata=16'hA5A5, ram_addr=8. A read @0x00010 gives gpu_data_in=16'h00A5 exactly 2 clocks after the address.
- 16-bit write 16'h1234 @0x00020, then 8-bit reads @0x00020 and @0x00021 on back-to-back clocks → 16'h0012 then 16'h0034, on consecutive cycles 2 clocks later.
- 16-bit write @0x00021 → same word as 0x00020 written, align_err=1, err_count=1. A 16-bit read @0x00020 returns the written value.
- Write @ byte 0x10000 (word 32768) with MEM_WORDS=32768 → ram_wren=0, oor_err=1, err_count+1. A read there returns 16'h0000 at latency 2.
- 300 out-of-range writes → err_count holds 8'hFF. err_clr asserted together with a further bad write → all error outputs 0 next cycle.
- reset_n asserted between read address and data return → gpu_data_in=0 immediately and stays 0 after release until a new read completes. ram_wren=0 during reset despite gpu_wr_ena=1.
